// File: rtl/word_entry.sv
// word_entry: debounced three-key byte-wise entry of a 32-bit word with valid/ready hand-off
module word_entry #(
  parameter int CNT_DEBOUNCE = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic [2:0]  key,
  input  logic        word_ready,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  display,
  output logic [3:0]  leds,
  output logic        busy
);
  typedef enum logic {ENTRY, HOLD} state_t;
  localparam logic [31:0] CMAX   = 32'(CNT_DEBOUNCE);
  localparam logic [31:0] CPULSE = 32'(CNT_DEBOUNCE - 1);
  state_t            state_q, state_d;
  logic [2:0][31:0]  cnt_q, cnt_d;
  logic [2:0]        p;
  logic [31:0]       buf_q, buf_d, word_q, word_d;
  logic [1:0]        ptr_q, ptr_d;
  // saturating hold counters; one-cycle press pulse when a count reaches CNT_DEBOUNCE-1
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = !key[i] ? '0 : cnt_q[i] == CMAX ? cnt_q[i] : cnt_q[i] + 32'd1;
      p[i] = cnt_q[i] == CPULSE;
    end
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ENTRY;
    else state_q <= state_d;
  // next state: commit enters HOLD, consumer acceptance returns to ENTRY
  always_comb state_d = state_q == ENTRY ? (p[2] ? HOLD : ENTRY) : (word_ready ? ENTRY : HOLD);
  // entry buffer, pointer and committed word; commit beats write beats back
  always_comb begin
    buf_d = buf_q;
    ptr_d = ptr_q;
    word_d = word_q;
    if (state_q == HOLD) begin
      if (word_ready) begin
        buf_d = '0;
        ptr_d = '0;
      end
    end else if (p[2]) word_d = buf_q;
    else if (p[0]) begin
      buf_d[{ptr_q, 3'b000} +: 8] = sw;
      ptr_d = ptr_q + 2'd1;
    end else if (p[1]) ptr_d = ptr_q - 2'd1;
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q  <= '0;
      buf_q  <= '0;
      ptr_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      ptr_q  <= ptr_d;
      word_q <= word_d;
    end
  // outputs echo the byte under the pointer; valid is exactly the HOLD state
  always_comb begin
    display    = buf_q[{ptr_q, 3'b000} +: 8];
    leds       = 4'b0001 << ptr_q;
    busy       = state_q == HOLD;
    word_valid = busy;
    word       = word_q;
  end
endmodule

// File: tb/tb_word_entry.sv
// tb_word_entry: directed and randomized checks of word_entry against a byte-array reference model
module tb_word_entry;
  localparam int CNT = 4;
  logic        clk = 0, rst = 1, word_ready = 0;
  logic [7:0]  sw = 0;
  logic [2:0]  key = 0;
  logic [31:0] word;
  logic        word_valid, busy;
  logic [7:0]  display;
  logic [3:0]  leds;
  int          checks = 0, errors = 0;
  int          hi[3];
  logic [7:0]  mb[4];
  int          mp;
  bit          mh;
  logic [31:0] mw;

  word_entry #(.CNT_DEBOUNCE(CNT)) dut (
    .clk(clk), .rst(rst), .sw(sw), .key(key), .word_ready(word_ready),
    .word(word), .word_valid(word_valid), .display(display), .leds(leds), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mb[i] = 8'h00;
    for (int i = 0; i < 3; i++) hi[i] = 0;
    mp = 0;
    mh = 0;
    mw = 0;
  endtask

  task automatic compare();
    check("word", word, mw);
    check("valid", {31'b0, word_valid}, {31'b0, mh});
    check("display", {24'b0, display}, {24'b0, mb[mp]});
    check("leds", {28'b0, leds}, 32'(1) << mp);
    check("busy", {31'b0, busy}, {31'b0, mh});
  endtask

  task automatic tick();
    bit pc, pw, pb;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      pw = hi[0] == CNT - 1;
      pb = hi[1] == CNT - 1;
      pc = hi[2] == CNT - 1;
      if (!mh) begin
        if (pc) begin
          mw = {mb[3], mb[2], mb[1], mb[0]};
          mh = 1;
        end else if (pw) begin
          mb[mp] = sw;
          mp = (mp + 1) % 4;
        end else if (pb) mp = (mp + 3) % 4;
      end else if (word_ready) begin
        mh = 0;
        mp = 0;
        for (int i = 0; i < 4; i++) mb[i] = 8'h00;
      end
      for (int i = 0; i < 3; i++) hi[i] = key[i] ? hi[i] + 1 : 0;
    end
    #1;
    compare();
  endtask

  task automatic press(input logic [2:0] k, input int n);
    key = k;
    repeat (n) tick();
    key = 0;
    repeat (2) tick();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    model_reset();
    compare();
    tick();
    rst = 0;
  endtask

  initial begin
    #1;
    model_reset();
    compare();
    tick();
    rst = 0;
    tick();
    // four bytes then commit
    sw = 8'h78; press(3'b001, CNT);
    sw = 8'h56; press(3'b001, CNT);
    sw = 8'h34; press(3'b001, CNT);
    sw = 8'h12; press(3'b001, CNT);
    check("leds_after_4_writes", {28'b0, leds}, 32'h1);
    press(3'b100, CNT);
    check("commit_word", word, 32'h12345678);
    check("commit_valid", {31'b0, word_valid}, 32'h1);
    check("commit_busy", {31'b0, busy}, 32'h1);
    // HOLD ignores keys while the consumer stalls
    sw = 8'hEE;
    for (int i = 0; i < 20; i++) begin
      key = (i % 10 < 5) ? 3'b001 : 3'b010;
      tick();
    end
    key = 0;
    repeat (2) tick();
    check("hold_word", word, 32'h12345678);
    check("hold_leds", {28'b0, leds}, 32'h1);
    check("hold_display", {24'b0, display}, 32'h78);
    word_ready = 1;
    tick();
    word_ready = 0;
    check("release_valid", {31'b0, word_valid}, 32'h0);
    check("release_leds", {28'b0, leds}, 32'h1);
    check("release_display", {24'b0, display}, 32'h0);
    check("release_word", word, 32'h12345678);
    tick();
    // back-wrap then write into byte 3
    do_reset();
    press(3'b010, CNT);
    check("back_wrap_leds", {28'b0, leds}, 32'h8);
    sw = 8'hAB; press(3'b001, CNT);
    check("wrap_write_leds", {28'b0, leds}, 32'h1);
    check("wrap_write_display", {24'b0, display}, 32'h0);
    press(3'b100, CNT);
    check("wrap_commit_word", word, 32'hAB000000);
    word_ready = 1;
    tick();
    word_ready = 0;
    // short hold gives nothing, long hold gives exactly one write
    sw = 8'h5A;
    press(3'b001, 2);
    check("short_hold_leds", {28'b0, leds}, 32'h1);
    check("short_hold_display", {24'b0, display}, 32'h0);
    press(3'b001, 100);
    check("long_hold_leds", {28'b0, leds}, 32'h2);
    press(3'b010, CNT);
    check("long_hold_byte0", {24'b0, display}, 32'h5A);
    // simultaneous commit and write: write dropped
    do_reset();
    sw = 8'h11; press(3'b001, CNT);
    sw = 8'hFF; press(3'b101, CNT);
    check("commit_priority_word", word, 32'h00000011);
    check("commit_priority_busy", {31'b0, busy}, 32'h1);
    check("commit_priority_leds", {28'b0, leds}, 32'h2);
    // asynchronous reset in HOLD
    tick();
    #2 rst = 1;
    #1;
    check("async_rst_word", word, 32'h0);
    check("async_rst_valid", {31'b0, word_valid}, 32'h0);
    check("async_rst_leds", {28'b0, leds}, 32'h1);
    check("async_rst_display", {24'b0, display}, 32'h0);
    model_reset();
    tick();
    rst = 0;
    repeat (3) tick();
    check("post_rst_word", word, 32'h0);
    check("post_rst_leds", {28'b0, leds}, 32'h1);
    // randomized key patterns, switches, consumer readiness and rare resets
    for (int n = 0; n < 600; n++) begin
      key = 3'($urandom_range(0, 7));
      sw = 8'($urandom);
      word_ready = $urandom_range(0, 3) == 0;
      repeat ($urandom_range(1, 7)) tick();
      if ($urandom_range(0, 3) == 0) begin
        key = 0;
        tick();
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1;
        #1;
        model_reset();
        compare();
        tick();
        rst = 0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/word_entry.md
Name: word_entry

Overview:
Operator-side input block for the two-digit seven-segment board: the counterpart to the byte-paged display path.
- The user composes a 32-bit word one byte at a time from 8 switches, using three debounced keys.
- Finished words are handed to the CPU/test logic over a valid/ready handshake.
- The current byte slot and its contents are exported, so the existing display/LED path can echo the entry.

Parameters:
CNT_DEBOUNCE, 500_000, number of clock cycles a key must be held high before one press pulse is emitted; bench uses 4.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
sw  input  8  byte value to be written
key  input  3  raw keys, pressed=1; key[0]=write, key[1]=back, key[2]=commit
word_ready  input  1  consumer accepts word when high at a clk edge while word_valid=1
word  output  32  committed word
word_valid  output  1  committed word available
display  output  8  byte of the entry buffer at the current pointer (feeds the segment driver)
leds  output  4  one-hot byte pointer (bit0 = byte 0)
busy  output  1  high while in HOLD

Behaviour:
- One clock domain, clk. rst is async active-high; all registers clear immediately on assertion.
- Reset values:
  - state=ENTRY, ptr=0, buf=0, word=0, word_valid=0, busy=0.
  - display=0x00, leds=4'b0001.
  - Debounce counters are 0.
- Debounce: one counter per key, 32 bits.
  - Key low: counter <= 0.
  - Key high: counter increments, saturating at CNT_DEBOUNCE.
  - Press pulse is combinational (counter == CNT_DEBOUNCE-1), so exactly one cycle of pulse per press, whatever the hold length.
  - A key high for fewer than CNT_DEBOUNCE-1 consecutive clocks produces no pulse.
  - Counters run in every state.
- ptr: 2-bit byte pointer into buf[31:0]; byte n = buf[8n+7:8n].
- State ENTRY, one action per cycle, priority commit > write > back. Lower-priority pulses in the same cycle are dropped.
  - commit: word <= buf, word_valid <= 1, state <= HOLD. buf and ptr are unchanged.
  - write: buf byte[ptr] <= sw, ptr <= ptr+1, wrapping 3 -> 0.
  - back: ptr <= ptr-1, wrapping 0 -> 3. buf is unchanged.
  - word_ready is ignored in ENTRY.
- State HOLD:
  - word_valid=1 and word stays stable; all key pulses are dropped, not queued.
  - On a clk edge with word_ready=1: word_valid <= 0, buf <= 0, ptr <= 0, state <= ENTRY. word keeps its last value.
  - word_ready may be held high permanently; minimum valid duration is 1 cycle.
- Combinational outputs:
  - display = buf byte[ptr].
  - leds = 1 << ptr.
  - busy = (state == HOLD).
- A commit with no prior writes is legal and transfers the current buf contents, including 0.
- rst asserted during HOLD drops word_valid asynchronously; no transfer is considered complete.

Test Plan:
1. Assert rst mid-simulation -> word=0, word_valid=0, leds=0001, display=00 within the same cycle; release -> values hold.
2. Write sw=78,56,34,12 in sequence (CNT_DEBOUNCE=4), then commit:
   - -> leds returns to 0001 after the 4th write;
   - -> word=0x12345678, word_valid=1, busy=1.
3. From reset, press back -> leds=1000; write sw=AB -> display shows 00 with leds=0001 (pointer advanced); commit -> word=0xAB000000.
4. key[0] high for 2 cycles -> no buf change. Held 100 cycles -> exactly one write, ptr advances by 1 only.
5. In HOLD, word_ready=0 for 20 cycles with write/back presses:
   - -> word, buf and ptr unchanged;
   - then word_ready=1 -> word_valid=0 at the next edge, buf=0, leds=0001, word still 0x12345678.
6. Commit and write pulses in the same cycle with sw=FF, after writing 11 to byte 0 -> word=0x00000011; the FF write is dropped.
